// File: rtl/tweet_ram_ctrl.sv
// tweet_ram_ctrl: arbiter/sequencer for the 256x16 tweet RAM (clear engine, serial writer, playback reader).
// Optional feature macro: TWEET_BACKSPACE_EN (0x08 deletes the last stored character).
module tweet_ram_ctrl #(
    parameter int unsigned MAX_LEN = 160
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        clr_req,
    input  logic        wr_valid,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    input  logic        rd_start,
    input  logic        rd_req,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    output logic        rd_end,
    output logic        ram_we,
    output logic [7:0]  ram_addr,
    output logic [15:0] ram_din,
    input  logic [15:0] ram_dout,
    output logic [7:0]  len,
    output logic        full,
    output logic        ovf,
    output logic        busy
);

    // Pointers carry a ninth bit so a MAX_LEN of 256 stays representable.
    localparam logic [8:0] MAX_PTR = 9'(MAX_LEN);

    typedef enum logic [2:0] {
        CLEAR   = 3'd0,
        IDLE    = 3'd1,
        WRITE   = 3'd2,
        RD_ADDR = 3'd3,
        RD_WAIT = 3'd4
    } state_t;

    state_t      state_r, state_s;
    logic        ram_we_r, ram_we_s;
    logic [7:0]  ram_addr_r, ram_addr_s, op_addr_s;
    logic [15:0] ram_din_r, ram_din_s;
    logic [8:0]  wr_ptr_r, wr_ptr_s;
    logic [8:0]  rd_ptr_r, rd_ptr_s, op_rd_ptr_s;
    logic        clr_pend_r, clr_pend_s;
    logic        rd_pend_r, rd_pend_s;
    logic        ovf_r, ovf_s;
    logic        rd_valid_r, rd_valid_s;
    logic [7:0]  rd_data_r, rd_data_s;
    logic        rd_end_r, rd_end_s;
    logic        wr_ready_r, wr_ready_s;
    logic        busy_r, busy_s;
    logic        full_r, full_s;
    logic        is_bs_s;
    logic        unused_dout_s;

`ifdef TWEET_BACKSPACE_EN
    assign is_bs_s = (wr_data == 8'h08);
`else
    assign is_bs_s = 1'b0;
`endif

    assign unused_dout_s = ^ram_dout[14:8];

    assign wr_ready = wr_ready_r;
    assign rd_valid = rd_valid_r;
    assign rd_data  = rd_data_r;
    assign rd_end   = rd_end_r;
    assign ram_we   = ram_we_r;
    assign ram_addr = ram_addr_r;
    assign ram_din  = ram_din_r;
    assign len      = wr_ptr_r[7:0];
    assign full     = full_r;
    assign ovf      = ovf_r;
    assign busy     = busy_r;

    // Next-state and next-output computation for every registered output.
    always_comb begin
        state_s     = state_r;
        ram_we_s    = 1'b0;
        op_addr_s   = ram_addr_r;
        ram_din_s   = ram_din_r;
        wr_ptr_s    = wr_ptr_r;
        op_rd_ptr_s = rd_ptr_r;
        clr_pend_s  = clr_pend_r | clr_req;
        rd_pend_s   = rd_pend_r | rd_req;
        ovf_s       = ovf_r;
        rd_valid_s  = 1'b0;
        rd_data_s   = rd_data_r;
        rd_end_s    = rd_end_r;
        case (state_r)
            CLEAR: begin
                ram_din_s = 16'h0000;
                if (!ram_we_r) begin
                    ram_we_s  = 1'b1;
                    op_addr_s = 8'h00;
                end else if (ram_addr_r == 8'hFF) begin
                    state_s     = IDLE;
                    wr_ptr_s    = 9'd0;
                    op_rd_ptr_s = 9'd0;
                    ovf_s       = 1'b0;
                end else begin
                    ram_we_s  = 1'b1;
                    op_addr_s = ram_addr_r + 8'd1;
                end
            end
            IDLE: begin
                if (clr_pend_r) begin
                    state_s    = CLEAR;
                    ram_we_s   = 1'b1;
                    op_addr_s  = 8'h00;
                    ram_din_s  = 16'h0000;
                    clr_pend_s = clr_req;
                end else if (wr_valid && wr_ready_r) begin
                    if (is_bs_s) begin
                        if (wr_ptr_r != 9'd0) begin
                            state_s   = WRITE;
                            ram_we_s  = 1'b1;
                            op_addr_s = wr_ptr_r[7:0] - 8'd1;
                            ram_din_s = 16'h0000;
                            wr_ptr_s  = wr_ptr_r - 9'd1;
                        end else begin
                            state_s = IDLE;
                        end
                    end else if (wr_ptr_r < MAX_PTR) begin
                        state_s   = WRITE;
                        ram_we_s  = 1'b1;
                        op_addr_s = wr_ptr_r[7:0];
                        ram_din_s = {1'b1, 7'b0000000, wr_data};
                        wr_ptr_s  = wr_ptr_r + 9'd1;
                    end else begin
                        ovf_s = 1'b1;
                    end
                end else if (rd_pend_r && !rd_start) begin
                    // ram_addr already equals rd_ptr here, so the RAM read starts on this edge.
                    state_s   = RD_ADDR;
                    rd_pend_s = rd_req;
                end else begin
                    state_s = IDLE;
                end
            end
            WRITE: begin
                state_s = IDLE;
            end
            RD_ADDR: begin
                state_s     = RD_WAIT;
                rd_valid_s  = 1'b1;
                rd_data_s   = ram_dout[7:0];
                rd_end_s    = ~ram_dout[15] | (rd_ptr_r == MAX_PTR);
                op_rd_ptr_s = rd_end_s ? rd_ptr_r : rd_ptr_r + 9'd1;
            end
            RD_WAIT: begin
                state_s = IDLE;
            end
            default: begin
                state_s   = CLEAR;
                op_addr_s = 8'h00;
            end
        endcase
        // A rewind always wins, which also cancels the increment of an in-flight read.
        rd_ptr_s   = rd_start ? 9'd0 : op_rd_ptr_s;
        ram_addr_s = (state_s == IDLE) ? rd_ptr_s[7:0] : op_addr_s;
        wr_ready_s = (state_s == IDLE) && !clr_pend_s;
        busy_s     = (state_s != IDLE);
        full_s     = (wr_ptr_s == MAX_PTR);
    end

    // State and output registers.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_r    <= CLEAR;
            ram_we_r   <= 1'b0;
            ram_addr_r <= 8'h00;
            ram_din_r  <= 16'h0000;
            wr_ptr_r   <= 9'd0;
            rd_ptr_r   <= 9'd0;
            clr_pend_r <= 1'b0;
            rd_pend_r  <= 1'b0;
            ovf_r      <= 1'b0;
            rd_valid_r <= 1'b0;
            rd_data_r  <= 8'h00;
            rd_end_r   <= 1'b0;
            wr_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            full_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            ram_we_r   <= ram_we_s;
            ram_addr_r <= ram_addr_s;
            ram_din_r  <= ram_din_s;
            wr_ptr_r   <= wr_ptr_s;
            rd_ptr_r   <= rd_ptr_s;
            clr_pend_r <= clr_pend_s;
            rd_pend_r  <= rd_pend_s;
            ovf_r      <= ovf_s;
            rd_valid_r <= rd_valid_s;
            rd_data_r  <= rd_data_s;
            rd_end_r   <= rd_end_s;
            wr_ready_r <= wr_ready_s;
            busy_r     <= busy_s;
            full_r     <= full_s;
        end
    end

endmodule

// File: tb/tb_tweet_ram_ctrl.sv
// Self-checking bench for tweet_ram_ctrl: directed vector table plus hand sequences for clear/full/reset cases.
`timescale 1ns/1ps
module tb_tweet_ram_ctrl;

    localparam int unsigned MAX_LEN = 160;
    localparam logic [1:0] OP_WR = 2'd0;
    localparam logic [1:0] OP_RS = 2'd1;
    localparam logic [1:0] OP_RD = 2'd2;
    localparam logic [1:0] OP_CL = 2'd3;

    typedef struct {
        logic [1:0] op;
        logic [7:0] data;
        logic [7:0] exp_data;
        logic       exp_end;
        logic [7:0] exp_len;
    } vec_t;

    logic        sysclk = 1'b0;
    logic        reset = 1'b1;
    logic        clr_req = 1'b0;
    logic        wr_valid = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        wr_ready;
    logic        rd_start = 1'b0;
    logic        rd_req = 1'b0;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        rd_end;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;
    logic [7:0]  len;
    logic        full;
    logic        ovf;
    logic        busy;

    logic [15:0] mem [0:255];
    logic        watch160 = 1'b0;
    int          hits160 = 0;
    int          checks = 0;
    int          errors = 0;
    vec_t        vecs[$];

    always #5 sysclk = ~sysclk;

    tweet_ram_ctrl #(.MAX_LEN(MAX_LEN)) dut (
        .sysclk(sysclk), .reset(reset), .clr_req(clr_req),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_start(rd_start), .rd_req(rd_req), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_end(rd_end), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .len(len), .full(full), .ovf(ovf), .busy(busy)
    );

    // Synchronous 256x16 RAM model with one-cycle read latency.
    always @(posedge sysclk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_din;
            if (watch160 && ram_addr == 8'd160) hits160 <= hits160 + 1;
        end
        ram_dout <= mem[ram_addr];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [7:0] d, input logic [7:0] ed,
                                input logic ee, input logic [7:0] el);
        vec_t v;
        v.op = op; v.data = d; v.exp_data = ed; v.exp_end = ee; v.exp_len = el;
        return v;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_wr_ready"}, wr_ready, 0);
        chk({tag, "_ram_we"}, ram_we, 0);
        chk({tag, "_ram_addr"}, ram_addr, 0);
        chk({tag, "_ram_din"}, ram_din, 0);
        chk({tag, "_len"}, len, 0);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_ovf"}, ovf, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_rd_end"}, rd_end, 0);
    endtask

    // Expects the next 256 cycles to write zeros to 0..255, then one IDLE cycle.
    task automatic expect_clear_sweep(input string tag);
        int bad = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (!(ram_we === 1'b1 && ram_addr === 8'(i) && ram_din === 16'h0000 &&
                  busy === 1'b1 && wr_ready === 1'b0)) bad++;
        end
        chk({tag, "_sweep_bad_cycles"}, bad, 0);
        tick();
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_we"}, ram_we, 0);
        chk({tag, "_idle_len"}, len, 0);
        chk({tag, "_idle_full"}, full, 0);
        chk({tag, "_idle_ovf"}, ovf, 0);
        chk({tag, "_idle_wr_ready"}, wr_ready, 1);
    endtask

    task automatic do_clear();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        chk("clr_pend_wr_ready", wr_ready, 0);
        chk("clr_pend_busy", busy, 0);
        expect_clear_sweep("clr");
    endtask

    task automatic write_byte(input logic [7:0] b);
        int n = 0;
        while (wr_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("wr_ready_timeout", wr_ready, 1);
        wr_valid = 1'b1;
        wr_data  = b;
        tick();
        wr_valid = 1'b0;
        tick();
    endtask

    task automatic read_byte(output logic [7:0] d, output logic e);
        int n = 0;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        while (rd_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("rd_valid_timeout", rd_valid, 1);
        d = rd_data;
        e = rd_end;
        tick();
    endtask

    task automatic rewind();
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        logic       e;
        int         bad;

        // "HI", readback to end, rewind, then the 0x08 character.
        vecs.push_back(mk(OP_WR, 8'h48, 8'h00, 1'b0, 8'd1));
        vecs.push_back(mk(OP_WR, 8'h49, 8'h00, 1'b0, 8'd2));
        vecs.push_back(mk(OP_RS, 8'h00, 8'h00, 1'b0, 8'd2));
        vecs.push_back(mk(OP_RD, 8'h00, 8'h48, 1'b0, 8'd2));
        vecs.push_back(mk(OP_RD, 8'h00, 8'h49, 1'b0, 8'd2));
        vecs.push_back(mk(OP_RD, 8'h00, 8'h00, 1'b1, 8'd2));
        vecs.push_back(mk(OP_RD, 8'h00, 8'h00, 1'b1, 8'd2));
        vecs.push_back(mk(OP_RS, 8'h00, 8'h00, 1'b0, 8'd2));
        vecs.push_back(mk(OP_RD, 8'h00, 8'h48, 1'b0, 8'd2));
`ifdef TWEET_BACKSPACE_EN
        vecs.push_back(mk(OP_WR, 8'h08, 8'h00, 1'b0, 8'd1));
        vecs.push_back(mk(OP_RS, 8'h00, 8'h00, 1'b0, 8'd1));
        vecs.push_back(mk(OP_RD, 8'h00, 8'h48, 1'b0, 8'd1));
        vecs.push_back(mk(OP_RD, 8'h00, 8'h00, 1'b1, 8'd1));
        vecs.push_back(mk(OP_CL, 8'h00, 8'h00, 1'b0, 8'd0));
        vecs.push_back(mk(OP_WR, 8'h41, 8'h00, 1'b0, 8'd1));
        vecs.push_back(mk(OP_WR, 8'h42, 8'h00, 1'b0, 8'd2));
        vecs.push_back(mk(OP_WR, 8'h08, 8'h00, 1'b0, 8'd1));
        vecs.push_back(mk(OP_WR, 8'h43, 8'h00, 1'b0, 8'd2));
        vecs.push_back(mk(OP_RS, 8'h00, 8'h00, 1'b0, 8'd2));
        vecs.push_back(mk(OP_RD, 8'h00, 8'h41, 1'b0, 8'd2));
        vecs.push_back(mk(OP_RD, 8'h00, 8'h43, 1'b0, 8'd2));
        vecs.push_back(mk(OP_RD, 8'h00, 8'h00, 1'b1, 8'd2));
        vecs.push_back(mk(OP_CL, 8'h00, 8'h00, 1'b0, 8'd0));
        vecs.push_back(mk(OP_WR, 8'h08, 8'h00, 1'b0, 8'd0));
        vecs.push_back(mk(OP_RS, 8'h00, 8'h00, 1'b0, 8'd0));
        vecs.push_back(mk(OP_RD, 8'h00, 8'h00, 1'b1, 8'd0));
`else
        vecs.push_back(mk(OP_WR, 8'h08, 8'h00, 1'b0, 8'd3));
        vecs.push_back(mk(OP_RS, 8'h00, 8'h00, 1'b0, 8'd3));
        vecs.push_back(mk(OP_RD, 8'h00, 8'h48, 1'b0, 8'd3));
        vecs.push_back(mk(OP_RD, 8'h00, 8'h49, 1'b0, 8'd3));
        vecs.push_back(mk(OP_RD, 8'h00, 8'h08, 1'b0, 8'd3));
        vecs.push_back(mk(OP_RD, 8'h00, 8'h00, 1'b1, 8'd3));
        vecs.push_back(mk(OP_CL, 8'h00, 8'h00, 1'b0, 8'd0));
        vecs.push_back(mk(OP_WR, 8'h41, 8'h00, 1'b0, 8'd1));
        vecs.push_back(mk(OP_WR, 8'h42, 8'h00, 1'b0, 8'd2));
        vecs.push_back(mk(OP_WR, 8'h08, 8'h00, 1'b0, 8'd3));
        vecs.push_back(mk(OP_WR, 8'h43, 8'h00, 1'b0, 8'd4));
        vecs.push_back(mk(OP_RS, 8'h00, 8'h00, 1'b0, 8'd4));
        vecs.push_back(mk(OP_RD, 8'h00, 8'h41, 1'b0, 8'd4));
        vecs.push_back(mk(OP_RD, 8'h00, 8'h42, 1'b0, 8'd4));
        vecs.push_back(mk(OP_RD, 8'h00, 8'h08, 1'b0, 8'd4));
        vecs.push_back(mk(OP_RD, 8'h00, 8'h43, 1'b0, 8'd4));
        vecs.push_back(mk(OP_RD, 8'h00, 8'h00, 1'b1, 8'd4));
`endif

        // Power-on reset and first clear sweep.
        tick(); tick(); tick();
        chk_reset_vals("por");
        reset = 1'b0;
        expect_clear_sweep("por");

        // Directed vector table.
        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].op)
                OP_WR: write_byte(vecs[i].data);
                OP_RS: rewind();
                OP_RD: begin
                    read_byte(d, e);
                    chk($sformatf("vec%0d_rd_data", i), d, vecs[i].exp_data);
                    chk($sformatf("vec%0d_rd_end", i), e, vecs[i].exp_end);
                end
                default: do_clear();
            endcase
            chk($sformatf("vec%0d_len", i), len, vecs[i].exp_len);
        end

        // clr_req together with wr_valid while a read is in flight; also checks read latency.
        do_clear();
        write_byte(8'h48);
        rewind();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("rdlat_pend_busy", busy, 0);
        chk("rdlat_pend_valid", rd_valid, 0);
        tick();
        chk("rdlat_addr_busy", busy, 1);
        chk("rdlat_addr_valid", rd_valid, 0);
        clr_req  = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h5A;
        tick();
        clr_req = 1'b0;
        chk("midrd_valid", rd_valid, 1);
        chk("midrd_data", rd_data, 8'h48);
        chk("midrd_end", rd_end, 0);
        chk("midrd_wr_ready", wr_ready, 0);
        tick();
        chk("midrd_idle_busy", busy, 0);
        chk("midrd_idle_wr_ready", wr_ready, 0);
        chk("midrd_len_held", len, 1);
        expect_clear_sweep("midrd");
        tick();
        wr_valid = 1'b0;
        chk("postclr_we", ram_we, 1);
        chk("postclr_addr", ram_addr, 8'h00);
        chk("postclr_din", ram_din, 16'h805A);
        chk("postclr_len", len, 1);
        chk("postclr_wr_ready_low", wr_ready, 0);
        tick();
        chk("postclr_wr_ready_back", wr_ready, 1);
        chk("postclr_we_off", ram_we, 0);
        rewind();
        read_byte(d, e);
        chk("postclr_rd_data", d, 8'h5A);
        chk("postclr_rd_end", e, 0);
        read_byte(d, e);
        chk("postclr_rd_end2", e, 1);

        // Fill to MAX_LEN, then one more byte.
        do_clear();
        watch160 = 1'b1;
        for (int i = 0; i < 159; i++) write_byte(8'(8'h41 + i % 26));
        chk("fill159_len", len, 8'd159);
        chk("fill159_full", full, 0);
        write_byte(8'(8'h41 + 159 % 26));
        chk("fill160_len", len, 8'd160);
        chk("fill160_full", full, 1);
        chk("fill160_ovf", ovf, 0);
        write_byte(8'h5A);
        watch160 = 1'b0;
        chk("fill161_len", len, 8'd160);
        chk("fill161_full", full, 1);
        chk("fill161_ovf", ovf, 1);
        chk("fill_addr160_writes", hits160, 0);
        rewind();
        bad = 0;
        for (int i = 0; i < 160; i++) begin
            read_byte(d, e);
            if (d !== 8'(8'h41 + i % 26) || e !== 1'b0) bad++;
        end
        chk("fill_readback_bad", bad, 0);
        read_byte(d, e);
        chk("fill_end_at_max", e, 1);
        read_byte(d, e);
        chk("fill_end_repeat", e, 1);

        // Reset asserted while a RAM write is pending.
        do_clear();
        write_byte(8'h51);
        wr_valid = 1'b1;
        wr_data  = 8'h52;
        tick();
        wr_valid = 1'b0;
        chk("rstwr_we", ram_we, 1);
        chk("rstwr_addr", ram_addr, 8'h01);
        reset = 1'b1;
        #1;
        chk_reset_vals("rstwr");
        tick();
        tick();
        chk("rstwr_mem1_untouched", mem[1], 16'h0000);
        chk("rstwr_mem0_kept", mem[0], 16'h8051);
        reset = 1'b0;
        expect_clear_sweep("rstwr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
